regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the pipelined RV32 cores; successor of the 2R1W IFRF.
//  - NRD combinational read ports and two write ports (A: ALU writeback, B: load writeback).
//  - Internal forwarding from both write ports; register 0 is hardwired to zero.
//  - A hardware clear engine zeroes the array one entry per cycle after reset or on request.
//  - Flop array, no BRAM, so a 2-stage pipeline still reads and writes in a single clock.
// PARAMETERS
//  XLEN  32  data width of each register
//  NREG  32  number of registers, power of two, >= 2
//  NRD   2   number of read ports, >= 1
//  AW    $clog2(NREG)  register address width (derived, not overridable)
// PORTS
//  clk       in   1        clock, all state updates on rising edge
//  resetb    in   1        asynchronous active-low reset
//  clr_req   in   1        pulse: restart the clear sweep (ignored while busy)
//  busy      out  1        1 while the clear sweep runs
//  a_rs      in   NRD*AW   read addresses; port k at [k*AW +: AW]
//  d_rs      out  NRD*XLEN read data; port k at [k*XLEN +: XLEN]
//  a_rda     in   AW       write port A address
//  d_rda     in   XLEN     write port A data
//  we_rda    in   1        write port A enable
//  a_rdb     in   AW       write port B address
//  d_rdb     in   XLEN     write port B data
//  we_rdb    in   1        write port B enable
// BEHAVIOUR
//  Reset (async, resetb=0):
//  - state=CLEAR, ptr=0, busy=1.
//  - Array contents are not reset by the flop reset itself; the sweep zeroes them.
//  FSM states and transitions:
//  - CLEAR: each cycle writes data[ptr]<=0, then ptr<=ptr+1.
//  - CLEAR: when ptr==NREG-1 is written, go to READY and set busy<=0 the next cycle.
//  - CLEAR: a full sweep takes exactly NREG cycles after reset deassertion.
//  - READY: busy=0; clr_req=1 sets ptr<=0, state<=CLEAR, busy<=1 on the next edge.
//  - clr_req while busy has no effect (the sweep is not restarted).
//  - Reset asserted mid-sweep: ptr and state return to the reset values immediately.
//  Writes:
//  - In READY, we_rdX=1 writes d_rdX to data[a_rdX] at the edge; visible from the array next cycle.
//  - Both ports enabled with the same address: port B wins and port A is dropped.
//  - Writes to address 0 are discarded.
//  - In CLEAR, all writes are ignored; the producer must stall on busy.
//  Reads (combinational, zero latency, per port k independently):
//  - If busy=1 or a_rs[k]==0, then d_rs[k]=0.
//  - Else if we_rdb && a_rdb!=0 && a_rdb==a_rs[k], then d_rs[k]=d_rdb.
//  - Else if we_rda && a_rda!=0 && a_rda==a_rs[k], then d_rs[k]=d_rda.
//  - Else d_rs[k]=data[a_rs[k]].
//  - All NRD ports may read the same address in the same cycle.
//  Width rules: addresses are exactly AW bits; no wrap-around or out-of-range case exists.
// TESTING
//  T1 Release resetb, count cycles -> busy=1 for exactly NREG cycles; then every d_rs reads 0.
//  T2 READY: we_rda=1, a_rda=5, d_rda=32'hDEADBEEF, a_rs port0=5 -> d_rs0=DEADBEEF same cycle.
//     Next cycle with we off -> d_rs0 still DEADBEEF.
//  T3 we_rda=1 a_rda=7 d=1 and we_rdb=1 a_rdb=7 d=2, same cycle -> forward 2; reg7 reads 2 afterwards.
//  T4 Write 32'hFFFF_FFFF to reg 0 on both ports -> a_rs=0 reads 0 during and after the write.
//  T5 Fill regs 1..NREG-1 with their index, pulse clr_req -> busy=1 for NREG cycles.
//     During the sweep: writes dropped, reads 0. After the sweep: all regs 0.
//  T6 Assert resetb=0 mid-sweep (ptr=10) for 1 cycle -> sweep restarts at 0; busy lasts NREG more cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port flop register file: NRD combinational read ports, two write
// ports (A = ALU writeback, B = load writeback), write-to-read forwarding,
// x0 hardwired to zero, and a one-entry-per-cycle clear sweep engine.
//
// Handshake: there is no valid/ready pair here. busy acts as a stall
// indication toward producers: while busy=1 every write is discarded and
// every read returns zero; the producer must hold its writeback until
// busy=0. A write is accepted exactly at a rising edge where busy=0 and its
// enable is high.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic                clr_req,
    output logic                busy,
    input  logic [NRD*AW-1:0]   a_rs,
    output logic [NRD*XLEN-1:0] d_rs,
    input  logic [AW-1:0]       a_rda,
    input  logic [XLEN-1:0]     d_rda,
    input  logic                we_rda,
    input  logic [AW-1:0]       a_rdb,
    input  logic [XLEN-1:0]     d_rdb,
    input  logic                we_rdb,
    output logic                dbg_state
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);
    localparam logic [AW-1:0] ZERO_IDX = '0;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] data_q [NREG];
    logic [XLEN-1:0] data_d [NREG];

    logic wr_a_ok;
    logic wr_b_ok;

    assign busy      = (state_q == CLEAR);
    assign dbg_state = state_q;
    assign wr_a_ok   = we_rda && (a_rda != ZERO_IDX);
    assign wr_b_ok   = we_rdb && (a_rdb != ZERO_IDX);

    // Control state and sweep pointer; reset restarts the sweep from entry 0.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= CLEAR;
            ptr_q   <= ZERO_IDX;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: sweep advances one entry per cycle, READY waits for clr_req.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + ONE_IDX;
                if (ptr_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = ZERO_IDX;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = ZERO_IDX;
            end
        endcase
    end

    // Array next value: sweep zeroes one entry, otherwise A then B (B wins on a tie).
    always_comb begin
        data_d = data_q;
        if (state_q == CLEAR) begin
            data_d[ptr_q] = '0;
        end else begin
            if (wr_a_ok) begin
                data_d[a_rda] = d_rda;
            end
            if (wr_b_ok) begin
                data_d[a_rdb] = d_rdb;
            end
        end
    end

    // Storage array is not reset by the flop reset; the sweep clears it.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rdata;

        assign addr = a_rs[k*AW +: AW];
        assign d_rs[k*XLEN +: XLEN] = rdata;

        // Read mux: zero during sweep or for x0, then forward B, then A, then array.
        always_comb begin
            rdata = '0;
            if (busy || (addr == ZERO_IDX)) begin
                rdata = '0;
            end else if (wr_b_ok && (a_rdb == addr)) begin
                rdata = d_rdb;
            end else if (wr_a_ok && (a_rda == addr)) begin
                rdata = d_rda;
            end else begin
                rdata = data_q[addr];
            end
        end
    end

endmodule
